control_multi: RTL and testbench

- Multicycle main controller FSM that sequences a shared MIPS-Lite datapath: one memory, one ALU, plus IR, A/B, ALUOut and MDR holding registers.
- Replaces the single-cycle opcode decoder with a state machine. Each instruction takes 3–5 cycles, plus wait cycles while memory is not ready.
- Drives all datapath mux selects and write enables.
- Supports R-type, lw, sw, beq and j.

---
 rtl/mips_ctl_pkg.sv | 44 ++++
 rtl/control_multi_outdec.sv | 119 +++++++++++
 rtl/control_multi.sv | 96 +++++++++
 tb/tb_control_multi.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mips_ctl_pkg.sv
// Shared encodings for the multicycle MIPS-Lite main controller:
// state numbering, opcodes and datapath select codes.
package mips_ctl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_supported = 1'b1;
      default:                              op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_multi_outdec.sv
// Combinational state -> datapath control decoder. Strobes are forced low
// while rst is high; selects follow the FETCH state the register resets to.
module control_multi_outdec
  import mips_ctl_pkg::*;
(
  input  logic       rst,
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_rdy,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op
);

  logic pc_write_s;
  logic pc_write_cond_s;
  logic mem_read_s;
  logic mem_write_s;
  logic ir_write_s;
  logic reg_write_s;
  logic instr_done_s;
  logic illegal_op_s;

  // Per-state decode; anything not assigned in a state stays 0.
  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    instr_done_s    = 1'b0;
    illegal_op_s    = 1'b0;
    IorD            = 1'b0;
    MemtoReg        = 1'b0;
    RegDst          = 1'b0;
    ALUSrcA         = 1'b0;
    ALUSrcB         = SRCB_REG;
    ALUOp           = ALUOP_ADD;
    PCSource        = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        mem_read_s = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ir_write_s = mem_rdy;
        pc_write_s = mem_rdy;
      end
      S_DECODE: begin
        ALUSrcB      = SRCB_IMM_SH2;
        illegal_op_s = ~op_supported(opcode);
        instr_done_s = ~op_supported(opcode);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        IorD       = 1'b1;
      end
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        MemtoReg     = 1'b1;
        instr_done_s = 1'b1;
      end
      S_MEMWR: begin
        mem_write_s  = 1'b1;
        IorD         = 1'b1;
        instr_done_s = mem_rdy;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        reg_write_s  = 1'b1;
        RegDst       = 1'b1;
        instr_done_s = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA         = 1'b1;
        ALUOp           = ALUOP_SUB;
        pc_write_cond_s = 1'b1;
        PCSource        = PCSRC_ALUOUT;
        instr_done_s    = 1'b1;
      end
      S_JUMP: begin
        pc_write_s   = 1'b1;
        PCSource     = PCSRC_JUMP;
        instr_done_s = 1'b1;
      end
      default: begin
        instr_done_s = 1'b0;
      end
    endcase
  end

  assign PCWrite     = pc_write_s      & ~rst;
  assign PCWriteCond = pc_write_cond_s & ~rst;
  assign MemRead     = mem_read_s      & ~rst;
  assign MemWrite    = mem_write_s     & ~rst;
  assign IRWrite     = ir_write_s      & ~rst;
  assign RegWrite    = reg_write_s     & ~rst;
  assign instr_done  = instr_done_s    & ~rst;
  assign illegal_op  = illegal_op_s    & ~rst;

endmodule

// File: rtl/control_multi.sv
// Multicycle main controller for the MIPS-Lite shared datapath: state
// register plus next-state logic; output decode lives in control_multi_outdec.
module control_multi
  import mips_ctl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_r;
  state_t next_state_s;
  logic   mem_rdy_s;

  // With waits disabled the memory is treated as always ready.
  assign mem_rdy_s = MEM_WAIT_EN ? mem_ready : 1'b1;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; opcode only matters in DECODE and MEMADR.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:    next_state_s = mem_rdy_s ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state_s = S_EXEC;
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_J:         next_state_s = S_JUMP;
          default:      next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state_s = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    next_state_s = mem_rdy_s ? S_MEMWB : S_MEMRD;
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWR:    next_state_s = mem_rdy_s ? S_FETCH : S_MEMWR;
      S_EXEC:     next_state_s = S_RTYPE_WB;
      S_RTYPE_WB: next_state_s = S_FETCH;
      S_BRANCH:   next_state_s = S_FETCH;
      S_JUMP:     next_state_s = S_FETCH;
      default:    next_state_s = S_FETCH;
    endcase
  end

  assign state = state_r;

  control_multi_outdec u_outdec (
    .rst         (rst),
    .state       (state_r),
    .opcode      (opcode),
    .mem_rdy     (mem_rdy_s),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

endmodule

// File: tb/tb_control_multi.sv
// Directed bench for control_multi: walks each instruction class cycle by
// cycle and compares state plus the full control word against hand values.
module tb_control_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  control_multi #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  // Control word: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
  //               RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource done illegal
  logic [17:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};

  localparam logic [17:0] C_RESET      = 18'b0_0_0_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_FETCH_RDY  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_FETCH_WAIT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DECODE     = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] C_ILLEGAL    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_1;
  localparam logic [17:0] C_MEMADR     = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MEMRD      = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MEMWB      = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] C_MEMWR_WAIT = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MEMWR_RDY  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] C_EXEC       = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] C_RTWB       = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] C_BRANCH     = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] C_JUMP       = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [3:0] st, input logic [17:0] c);
    #1;
    check_eq({tag, "/state"}, 32'(state), 32'(st));
    check_eq({tag, "/ctl"}, 32'(ctl), 32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'h23;
    repeat (2) tick();
    expect_cyc("rst_init", 4'd0, C_RESET);

    // lw, memory always ready: 0,1,2,3,4
    rst = 1'b0;
    expect_cyc("lw_f", 4'd0, C_FETCH_RDY);
    tick(); expect_cyc("lw_d",  4'd1, C_DECODE);
    tick(); expect_cyc("lw_ma", 4'd2, C_MEMADR);
    tick(); expect_cyc("lw_rd", 4'd3, C_MEMRD);
    tick(); expect_cyc("lw_wb", 4'd4, C_MEMWB);
    tick(); expect_cyc("lw_end", 4'd0, C_FETCH_RDY);

    // lw with one wait cycle in MEMRD
    tick(); expect_cyc("lw2_d",  4'd1, C_DECODE);
    tick(); expect_cyc("lw2_ma", 4'd2, C_MEMADR);
    tick(); mem_ready = 1'b0; expect_cyc("lw2_rdw", 4'd3, C_MEMRD);
    tick(); mem_ready = 1'b1; expect_cyc("lw2_rd",  4'd3, C_MEMRD);
    tick(); expect_cyc("lw2_wb", 4'd4, C_MEMWB);
    tick(); opcode = 6'h2B; expect_cyc("sw_f", 4'd0, C_FETCH_RDY);

    // sw with two wait cycles in MEMWR: six cycles total
    tick(); expect_cyc("sw_d",  4'd1, C_DECODE);
    tick(); expect_cyc("sw_ma", 4'd2, C_MEMADR);
    tick(); mem_ready = 1'b0; expect_cyc("sw_w1", 4'd5, C_MEMWR_WAIT);
    tick(); expect_cyc("sw_w2", 4'd5, C_MEMWR_WAIT);
    tick(); mem_ready = 1'b1; expect_cyc("sw_w3", 4'd5, C_MEMWR_RDY);
    tick(); opcode = 6'h00; expect_cyc("sw_end", 4'd0, C_FETCH_RDY);

    // R-type; opcode change during EXEC must be ignored
    tick(); expect_cyc("rt_d", 4'd1, C_DECODE);
    tick(); opcode = 6'h23; expect_cyc("rt_ex", 4'd6, C_EXEC);
    tick(); opcode = 6'h04; expect_cyc("rt_wb", 4'd7, C_RTWB);

    // beq
    tick(); expect_cyc("beq_f", 4'd0, C_FETCH_RDY);
    tick(); expect_cyc("beq_d", 4'd1, C_DECODE);
    tick(); expect_cyc("beq_br", 4'd8, C_BRANCH);

    // four fetch stall cycles, then jump
    tick(); mem_ready = 1'b0; expect_cyc("stall_0", 4'd0, C_FETCH_WAIT);
    for (int i = 1; i < 4; i++) begin
      tick(); expect_cyc($sformatf("stall_%0d", i), 4'd0, C_FETCH_WAIT);
    end
    tick(); mem_ready = 1'b1; opcode = 6'h02; expect_cyc("j_f", 4'd0, C_FETCH_RDY);
    tick(); expect_cyc("j_d", 4'd1, C_DECODE);
    tick(); expect_cyc("j_j", 4'd9, C_JUMP);
    tick(); opcode = 6'h3F; expect_cyc("ill_f", 4'd0, C_FETCH_RDY);

    // illegal opcode: two cycles, no writes
    tick(); expect_cyc("ill_d", 4'd1, C_ILLEGAL);
    tick(); opcode = 6'h00; expect_cyc("ill_end", 4'd0, C_FETCH_RDY);

    // reset held for three cycles in the middle of EXEC
    tick(); expect_cyc("rm_d",  4'd1, C_DECODE);
    tick(); expect_cyc("rm_ex", 4'd6, C_EXEC);
    rst = 1'b1;
    expect_cyc("rm_async", 4'd0, C_RESET);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_cyc($sformatf("rm_hold%0d", i), 4'd0, C_RESET);
    end
    rst = 1'b0;
    expect_cyc("rm_rel", 4'd0, C_FETCH_RDY);
    tick(); expect_cyc("rm_d2", 4'd1, C_DECODE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
